// File: rtl/pong_pkg.sv
// pong_pkg: types and default constants shared by the pingpong game engine.
//   state_e : game FSM state (IDLE, PLAY, MISS, OVER), 2-bit, matches the
//             numeric codes reported on the ball_engine state port.
//   coord_t : 11-bit unsigned screen coordinate.
//   svel_t  : 12-bit signed value for velocities and signed position math.
//   DEF_*   : default geometry and velocity values used as module parameters.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_MISS = 2'd2,
    ST_OVER = 2'd3
  } state_e;

  typedef logic [10:0]        coord_t;
  typedef logic signed [11:0] svel_t;

  localparam int DEF_H_RES       = 1280;
  localparam int DEF_V_RES       = 1024;
  localparam int DEF_BALL_R      = 10;
  localparam int DEF_PAT_X       = 1100;
  localparam int DEF_PAT_W       = 20;
  localparam int DEF_PAT_H       = 100;
  localparam int DEF_PAT_STEP    = 8;
  localparam int DEF_SERVE_X     = 200;
  localparam int DEF_VX0         = 6;
  localparam int DEF_VY0         = 4;
  localparam int DEF_MISS_FRAMES = 60;
  localparam int DEF_MAX_MISS    = 9;

endpackage

// File: rtl/paddle_ctrl.sv
// paddle_ctrl: vertical paddle position, moved once per frame tick.
// Ports:
//   clk, reset     : clock, synchronous active-low reset
//   tick           : one-cycle frame tick
//   enable         : paddle may move on this tick (low while the game is over)
//   pat_up, pat_dn : player buttons (level); both or neither means hold
//   ypat           : paddle centre y, clamped to keep the paddle on screen
//   ypat_old       : paddle centre y before this tick's move; the collision
//                    logic must use this so a hit is judged against the
//                    paddle the player could see
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int V_RES    = DEF_V_RES,
  parameter int PAT_H    = DEF_PAT_H,
  parameter int PAT_STEP = DEF_PAT_STEP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        enable,
  input  logic        pat_up,
  input  logic        pat_dn,
  output logic [10:0] ypat,
  output logic [10:0] ypat_old
);

  localparam svel_t  Y_MIN = svel_t'(PAT_H / 2);
  localparam svel_t  Y_MAX = svel_t'(V_RES - 1 - PAT_H / 2);
  localparam svel_t  STEP  = svel_t'(PAT_STEP);
  localparam coord_t Y_RST = coord_t'(V_RES / 2);

  coord_t ypat_q;
  coord_t ypat_next;
  svel_t  y_s;
  svel_t  y_up;
  svel_t  y_dn;

  // Next paddle position; signed math so a step past the top edge clamps
  // instead of wrapping around.
  always_comb begin
    y_s       = $signed({1'b0, ypat_q});
    y_up      = y_s - STEP;
    y_dn      = y_s + STEP;
    ypat_next = ypat_q;
    if (tick && enable) begin
      if (pat_up && !pat_dn) begin
        ypat_next = (y_up < Y_MIN) ? Y_MIN[10:0] : y_up[10:0];
      end else if (pat_dn && !pat_up) begin
        ypat_next = (y_dn > Y_MAX) ? Y_MAX[10:0] : y_dn[10:0];
      end
    end
  end

  // Paddle position register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ypat_q <= Y_RST;
    end else begin
      ypat_q <= ypat_next;
    end
  end

  // The ball logic updates on the same edge as the paddle, so the current
  // register value is the pre-move position it needs.
  assign ypat     = ypat_q;
  assign ypat_old = ypat_q;

endmodule

// File: rtl/ball_engine.sv
// ball_engine: per-frame game state for the pingpong display path.
// Ports:
//   clk, reset     : clock shared with the renderer, synchronous active-low reset
//   vsync          : renderer sync (active low); its falling edge is the frame tick
//   serve          : serve/restart button (level, rising edge acts)
//   pat_up, pat_dn : paddle buttons (level)
//   xball, yball   : ball centre
//   xpat, ypat     : paddle centre (xpat is fixed)
//   hits           : paddle hits, saturating at 255
//   misses         : miss count, never above MAX_MISS
//   state          : 0 IDLE, 1 PLAY, 2 MISS, 3 OVER
module ball_engine
  import pong_pkg::*;
#(
  parameter int H_RES       = DEF_H_RES,
  parameter int V_RES       = DEF_V_RES,
  parameter int BALL_R      = DEF_BALL_R,
  parameter int PAT_X       = DEF_PAT_X,
  parameter int PAT_W       = DEF_PAT_W,
  parameter int PAT_H       = DEF_PAT_H,
  parameter int PAT_STEP    = DEF_PAT_STEP,
  parameter int SERVE_X     = DEF_SERVE_X,
  parameter int VX0         = DEF_VX0,
  parameter int VY0         = DEF_VY0,
  parameter int MISS_FRAMES = DEF_MISS_FRAMES,
  parameter int MAX_MISS    = DEF_MAX_MISS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync,
  input  logic        serve,
  input  logic        pat_up,
  input  logic        pat_dn,
  output logic [10:0] xball,
  output logic [10:0] yball,
  output logic [10:0] xpat,
  output logic [10:0] ypat,
  output logic [7:0]  hits,
  output logic [3:0]  misses,
  output logic [1:0]  state
);

  localparam int     CW      = $clog2(MISS_FRAMES + 1);
  localparam coord_t PARK_X  = coord_t'(SERVE_X);
  localparam coord_t PARK_Y  = coord_t'(V_RES / 2);
  localparam svel_t  R_S     = svel_t'(BALL_R);
  localparam svel_t  YBOT_S  = svel_t'(V_RES - 1);
  localparam svel_t  XRGT_S  = svel_t'(H_RES - 1);
  localparam svel_t  FACE_S  = svel_t'(PAT_X - PAT_W / 2);
  localparam svel_t  REACH_S = svel_t'(PAT_H / 2 + BALL_R);
  localparam svel_t  VX0_S   = svel_t'(VX0);
  localparam svel_t  VY0_S   = svel_t'(VY0);

  state_e          state_q;
  state_e          state_next;
  coord_t          x_q;
  coord_t          y_q;
  svel_t           vx_q;
  svel_t           vy_q;
  logic [7:0]      hits_q;
  logic [3:0]      misses_q;
  logic            sign_q;
  logic [CW-1:0]   miss_cnt_q;
  logic            miss_done;

  logic            vs_d1;
  logic            vs_d2;
  logic            tick;
  logic            sv_d1;
  logic            sv_d2;
  logic            serve_edge;

  coord_t          ypat_cur;
  coord_t          ypat_old;

  svel_t           xs;
  svel_t           ys;
  svel_t           xn;
  svel_t           yn;
  svel_t           yp_s;
  svel_t           vx_abs;
  svel_t           vy_abs;
  svel_t           dy;
  svel_t           dy_abs;
  coord_t          x_play;
  coord_t          y_play;
  svel_t           vx_play;
  svel_t           vy_play;
  logic            hit_play;
  logic            miss_play;

  // Edge detectors: a vsync fall becomes a one-cycle tick, a serve rise a
  // one-cycle serve_edge. Reset preloads the history to 1 so a serve button
  // already held across reset produces no edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vs_d1      <= 1'b1;
      vs_d2      <= 1'b1;
      tick       <= 1'b0;
      sv_d1      <= 1'b1;
      sv_d2      <= 1'b1;
      serve_edge <= 1'b0;
    end else begin
      vs_d1      <= vsync;
      vs_d2      <= vs_d1;
      tick       <= vs_d2 & ~vs_d1;
      sv_d1      <= serve;
      sv_d2      <= sv_d1;
      serve_edge <= sv_d1 & ~sv_d2;
    end
  end

  paddle_ctrl #(
    .V_RES    (V_RES),
    .PAT_H    (PAT_H),
    .PAT_STEP (PAT_STEP)
  ) u_paddle (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .enable   (state_q != ST_OVER),
    .pat_up   (pat_up),
    .pat_dn   (pat_dn),
    .ypat     (ypat_cur),
    .ypat_old (ypat_old)
  );

  // Candidate ball state for a PLAY tick. Y and X are reflected
  // independently so a corner bounces both axes in one frame; the paddle
  // window uses the unreflected yn against the pre-move paddle position.
  always_comb begin
    xs     = $signed({1'b0, x_q});
    ys     = $signed({1'b0, y_q});
    yp_s   = $signed({1'b0, ypat_old});
    xn     = xs + vx_q;
    yn     = ys + vy_q;
    vx_abs = vx_q[11] ? -vx_q : vx_q;
    vy_abs = vy_q[11] ? -vy_q : vy_q;
    dy     = yn - yp_s;
    dy_abs = dy[11] ? -dy : dy;

    y_play  = yn[10:0];
    vy_play = vy_q;
    if ((yn - R_S) <= 12'sd0) begin
      y_play  = R_S[10:0];
      vy_play = vy_abs;
    end else if ((yn + R_S) >= YBOT_S) begin
      y_play  = coord_t'(V_RES - 1 - BALL_R);
      vy_play = -vy_abs;
    end

    x_play    = xn[10:0];
    vx_play   = vx_q;
    hit_play  = 1'b0;
    miss_play = 1'b0;
    if ((xn - R_S) <= 12'sd0) begin
      x_play  = R_S[10:0];
      vx_play = vx_abs;
    end else if ((vx_q > 12'sd0) && ((xs + R_S) < FACE_S) &&
                 ((xn + R_S) >= FACE_S) && (dy_abs <= REACH_S)) begin
      x_play   = coord_t'(PAT_X - PAT_W / 2 - BALL_R);
      vx_play  = -vx_abs;
      hit_play = 1'b1;
    end else if ((xn + R_S) >= XRGT_S) begin
      x_play    = coord_t'(H_RES - 1 - BALL_R);
      miss_play = 1'b1;
    end
  end

  assign miss_done = (miss_cnt_q == CW'(MISS_FRAMES - 1));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // FSM next state: serve edges drive IDLE/OVER, ticks drive PLAY/MISS.
  always_comb begin
    state_next = state_q;
    case (state_q)
      ST_IDLE: if (serve_edge) state_next = ST_PLAY;
      ST_PLAY: if (tick && miss_play) state_next = ST_MISS;
      ST_MISS: begin
        if (tick && miss_done) begin
          state_next = (misses_q == 4'(MAX_MISS)) ? ST_OVER : ST_IDLE;
        end
      end
      ST_OVER: if (serve_edge) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Ball, velocity and counter registers. Leaving MISS for IDLE and leaving
  // OVER both re-park the ball at the serve point.
  always_ff @(posedge clk) begin
    if (!reset) begin
      x_q        <= PARK_X;
      y_q        <= PARK_Y;
      vx_q       <= VX0_S;
      vy_q       <= VY0_S;
      hits_q     <= '0;
      misses_q   <= '0;
      sign_q     <= 1'b0;
      miss_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (serve_edge) begin
            vx_q   <= VX0_S;
            vy_q   <= sign_q ? -VY0_S : VY0_S;
            sign_q <= ~sign_q;
          end
        end
        ST_PLAY: begin
          if (tick) begin
            x_q        <= x_play;
            y_q        <= y_play;
            vx_q       <= vx_play;
            vy_q       <= vy_play;
            miss_cnt_q <= '0;
            if (hit_play && (hits_q != 8'hFF)) begin
              hits_q <= hits_q + 8'd1;
            end
            if (miss_play && (misses_q != 4'(MAX_MISS))) begin
              misses_q <= misses_q + 4'd1;
            end
          end
        end
        ST_MISS: begin
          if (tick) begin
            if (miss_done) begin
              miss_cnt_q <= '0;
              if (misses_q != 4'(MAX_MISS)) begin
                x_q <= PARK_X;
                y_q <= PARK_Y;
              end
            end else begin
              miss_cnt_q <= miss_cnt_q + CW'(1);
            end
          end
        end
        ST_OVER: begin
          if (serve_edge) begin
            hits_q   <= '0;
            misses_q <= '0;
            x_q      <= PARK_X;
            y_q      <= PARK_Y;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    xball  = x_q;
    yball  = y_q;
    xpat   = coord_t'(PAT_X);
    ypat   = ypat_cur;
    hits   = hits_q;
    misses = misses_q;
    state  = state_q;
  end

endmodule

// File: tb/tb_ball_engine.sv
// tb_ball_engine: self-checking bench for ball_engine. A frame-level integer
// model of the game rules predicts every output after each serve or frame.
module tb_ball_engine;

  localparam int H_RES       = 1280;
  localparam int V_RES       = 1024;
  localparam int BALL_R      = 10;
  localparam int PAT_X       = 1100;
  localparam int PAT_W       = 20;
  localparam int PAT_H       = 100;
  localparam int PAT_STEP    = 8;
  localparam int SERVE_X     = 200;
  localparam int VX0         = 6;
  localparam int VY0         = 4;
  localparam int MISS_FRAMES = 60;
  localparam int MAX_MISS    = 9;

  logic        clk;
  logic        reset;
  logic        vsync;
  logic        serve;
  logic        pat_up;
  logic        pat_dn;
  logic [10:0] xball;
  logic [10:0] yball;
  logic [10:0] xpat;
  logic [10:0] ypat;
  logic [7:0]  hits;
  logic [3:0]  misses;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  // model state: ball, velocity, paddle, counters, state code, serve sign
  int m_x, m_y, m_vx, m_vy, m_yp, m_hits, m_miss, m_st, m_cnt;
  bit m_sign;

  ball_engine dut (
    .clk    (clk),
    .reset  (reset),
    .vsync  (vsync),
    .serve  (serve),
    .pat_up (pat_up),
    .pat_dn (pat_dn),
    .xball  (xball),
    .yball  (yball),
    .xpat   (xpat),
    .ypat   (ypat),
    .hits   (hits),
    .misses (misses),
    .state  (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic modelReset();
    m_x = SERVE_X; m_y = V_RES / 2; m_vx = VX0; m_vy = VY0;
    m_yp = V_RES / 2; m_hits = 0; m_miss = 0; m_st = 0; m_cnt = 0;
    m_sign = 1'b0;
  endtask

  task automatic modelBall(input int yp_old);
    int xn, yn, face;
    xn   = m_x + m_vx;
    yn   = m_y + m_vy;
    face = PAT_X - PAT_W / 2;
    if (yn - BALL_R <= 0) begin
      m_y = BALL_R; m_vy = iabs(m_vy);
    end else if (yn + BALL_R >= V_RES - 1) begin
      m_y = V_RES - 1 - BALL_R; m_vy = -iabs(m_vy);
    end else begin
      m_y = yn;
    end
    if (xn - BALL_R <= 0) begin
      m_x = BALL_R; m_vx = iabs(m_vx);
    end else if (m_vx > 0 && m_x + BALL_R < face && xn + BALL_R >= face &&
                 iabs(yn - yp_old) <= PAT_H / 2 + BALL_R) begin
      m_x = face - BALL_R; m_vx = -iabs(m_vx);
      if (m_hits < 255) m_hits++;
    end else if (xn + BALL_R >= H_RES - 1) begin
      m_x = H_RES - 1 - BALL_R; m_st = 2; m_cnt = 0;
      if (m_miss < MAX_MISS) m_miss++;
    end else begin
      m_x = xn;
    end
  endtask

  // One frame/serve event of the game rules, judged from the state at entry.
  task automatic modelStep(input bit srv, input bit tk, input bit up, input bit dn);
    int old_st, old_yp;
    old_st = m_st;
    old_yp = m_yp;
    if (tk && old_st != 3) begin
      if (up && !dn) m_yp = (m_yp - PAT_STEP < PAT_H / 2) ? PAT_H / 2 : m_yp - PAT_STEP;
      else if (dn && !up) m_yp = (m_yp + PAT_STEP > V_RES - 1 - PAT_H / 2) ?
                                 V_RES - 1 - PAT_H / 2 : m_yp + PAT_STEP;
    end
    case (old_st)
      0: if (srv) begin
        m_st = 1; m_vx = VX0; m_vy = m_sign ? -VY0 : VY0; m_sign = !m_sign;
      end
      1: if (tk) modelBall(old_yp);
      2: if (tk) begin
        m_cnt++;
        if (m_cnt == MISS_FRAMES) begin
          m_cnt = 0;
          if (m_miss == MAX_MISS) m_st = 3;
          else begin m_st = 0; m_x = SERVE_X; m_y = V_RES / 2; end
        end
      end
      default: if (srv) begin
        m_hits = 0; m_miss = 0; m_st = 0; m_x = SERVE_X; m_y = V_RES / 2;
      end
    endcase
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".xball"},  32'(xball),  m_x);
    checkVal({tag, ".yball"},  32'(yball),  m_y);
    checkVal({tag, ".xpat"},   32'(xpat),   PAT_X);
    checkVal({tag, ".ypat"},   32'(ypat),   m_yp);
    checkVal({tag, ".hits"},   32'(hits),   m_hits);
    checkVal({tag, ".misses"}, 32'(misses), m_miss);
    checkVal({tag, ".state"},  32'(state),  m_st);
  endtask

  // Drive one serve and/or vsync pulse, let the DUT settle, advance the model.
  task automatic applyStimulus(input bit up, input bit dn, input bit srv, input bit vs);
    @(negedge clk);
    pat_up = up;
    pat_dn = dn;
    if (srv) serve = 1'b1;
    if (vs) vsync = 1'b0;
    repeat (2) @(negedge clk);
    vsync = 1'b1;
    serve = 1'b0;
    repeat (4) @(negedge clk);
    modelStep(srv, vs, up, dn);
  endtask

  task automatic randomFrame(input string tag);
    applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    checkOutput(tag);
  endtask

  initial begin
    bit dir_up;
    int yp_before;
    reset = 1'b0; vsync = 1'b1; serve = 1'b0; pat_up = 1'b0; pat_dn = 1'b0;
    repeat (3) @(negedge clk);
    modelReset();
    checkOutput("reset");
    reset = 1'b1;

    $display("[TB] idle frames");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("idle");
    end

    $display("[TB] serve, bottom wall, paddle hit");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("serve");
    for (int t = 1; t <= 147; t++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput("play");
      if (t == 1) begin
        checkVal("t1.xball", 32'(xball), 206);
        checkVal("t1.yball", 32'(yball), 516);
      end
      if (t == 126) checkVal("t126.yball", 32'(yball), 1013);
      if (t == 127) checkVal("t127.yball", 32'(yball), 1009);
      if (t == 147) begin
        checkVal("t147.xball", 32'(xball), 1080);
        checkVal("t147.hits",  32'(hits),  1);
        checkVal("t147.ypat",  32'(ypat),  973);
      end
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkVal("t148.xball", 32'(xball), 1074);
    checkOutput("after_hit");

    $display("[TB] reset mid-play with serve held");
    @(negedge clk);
    reset = 1'b0;
    serve = 1'b1;
    @(negedge clk);
    modelReset();
    checkOutput("midrst");
    reset = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("held_serve");
    serve = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] miss");
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("park_up");
    end
    checkVal("park_up.ypat", 32'(ypat), 50);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("serve2");
    for (int k = 0; k < 400 && m_st == 1; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("to_miss");
    end
    checkVal("miss.xball",  32'(xball),  1269);
    checkVal("miss.state",  32'(state),  2);
    checkVal("miss.misses", 32'(misses), 1);
    for (int i = 0; i < MISS_FRAMES; i++) randomFrame("miss_hold");
    checkVal("repark.state", 32'(state), 0);
    checkVal("repark.xball", 32'(xball), 200);
    checkVal("repark.yball", 32'(yball), 512);

    $display("[TB] game over");
    for (int g = 2; g <= MAX_MISS; g++) begin
      dir_up = !m_sign;
      for (int i = 0; i < 120; i++) begin
        applyStimulus(dir_up, !dir_up, 1'b0, 1'b1);
        checkOutput("g_idle");
      end
      applyStimulus(dir_up, !dir_up, 1'b1, 1'b0);
      checkOutput("g_serve");
      for (int k = 0; k < 600 && m_st == 1; k++) begin
        applyStimulus(dir_up, !dir_up, 1'b0, 1'b1);
        checkOutput("g_play");
      end
      for (int k = 0; k < 100 && m_st == 2; k++) randomFrame("g_miss");
    end
    checkVal("over.state",  32'(state),  3);
    checkVal("over.misses", 32'(misses), MAX_MISS);
    for (int i = 0; i < 3; i++) randomFrame("over_frozen");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("restart");
    checkVal("restart.hits",   32'(hits),   0);
    checkVal("restart.misses", 32'(misses), 0);
    checkVal("restart.state",  32'(state),  0);

    $display("[TB] serve on tick, both buttons");
    yp_before = m_yp;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("serve_tick");
    checkVal("both.ypat",        32'(ypat),  yp_before);
    checkVal("serve_tick.state", 32'(state), 1);
    checkVal("serve_tick.xball", 32'(xball), 200);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkVal("first_move.xball", 32'(xball), 206);
    checkOutput("first_move");

    $display("[TB] random play");
    for (int i = 0; i < 200; i++) randomFrame("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ball_engine.md
# ball_engine

Game-state engine for the pingpong display path. Once per video frame it advances ball position, applies wall and paddle reflections, moves the paddle from player inputs, and tracks hits and misses. It feeds `xball`, `yball`, `xpat` and `ypat` to the VGA renderer. Its only input from the renderer is `vsync`, which it uses as the frame tick.

## Interface
Parameters:
- `H_RES`, 1280: visible width in pixels.
- `V_RES`, 1024: visible height in pixels.
- `BALL_R`, 10: ball half-size.
- `PAT_X`, 1100: paddle centre x; fixed.
- `PAT_W`, 20: paddle width.
- `PAT_H`, 100: paddle height.
- `PAT_STEP`, 8: paddle move per frame.
- `SERVE_X`, 200: ball x at serve.
- `VX0`, 6: serve |vx| per frame.
- `VY0`, 4: serve |vy| per frame.
- `MISS_FRAMES`, 60: frames held after a miss.
- `MAX_MISS`, 9: misses that end the game.

Ports:
- `clk` in 1: system clock, same clock as the renderer.
- `reset` in 1: synchronous, active-low.
- `vsync` in 1: from the renderer; active-low sync pulse.
- `serve` in 1: serve/restart button, level.
- `pat_up` in 1: move paddle up, level.
- `pat_dn` in 1: move paddle down, level.
- `xball` out 11: ball centre x.
- `yball` out 11: ball centre y.
- `xpat` out 11: paddle centre x; always `PAT_X`.
- `ypat` out 11: paddle centre y.
- `hits` out 8: paddle hits; saturates at 255.
- `misses` out 4: miss count.
- `state` out 2: 0 IDLE, 1 PLAY, 2 MISS, 3 OVER.

## Operation
- Frame tick: registered falling-edge detect of `vsync`. `serve` uses a registered rising-edge detect.
- All state updates happen only on a tick, except serve handling.
- FSM:
  - IDLE: ball parked at (`SERVE_X`, `V_RES/2`). A serve edge moves to PLAY with vx=+`VX0` and vy=±`VY0`. vy sign alternates each serve; the first serve after reset is +.
  - PLAY: ball update on each tick (rules below).
  - MISS: entered when the ball passes the paddle. On entry `misses`+1 and the ball freezes. After `MISS_FRAMES` ticks: go to OVER if `misses`==`MAX_MISS`, else go to IDLE with the ball re-parked.
  - OVER: positions frozen. A serve edge clears `hits` and `misses` and goes to IDLE.
  - A serve edge in PLAY or MISS is ignored.
- Ball update in PLAY:
  - Compute xn = x+vx and yn = y+vy in signed 12-bit.
  - Y reflection:
    - If yn−R ≤ 0: y=R, vy=+|vy|.
    - Else if yn+R ≥ V_RES−1: y=V_RES−1−R, vy=−|vy|.
    - Else y=yn.
  - X reflection (priority order):
    - Left wall: xn−R ≤ 0 → x=R, vx=+|vx|.
    - Paddle: vx>0, x+R < PAT_X−PAT_W/2, xn+R ≥ PAT_X−PAT_W/2, and |yn−ypat_old| ≤ PAT_H/2+R → x=PAT_X−PAT_W/2−R, vx=−|vx|, `hits`+1.
    - Miss: xn+R ≥ H_RES−1 → x=H_RES−1−R, go to MISS.
    - Otherwise x=xn.
  - X and Y reflections are independent; a corner reflects both in the same frame.
- Paddle update, every tick in IDLE, PLAY and MISS:
  - up only: ypat −= PAT_STEP, clamped at PAT_H/2.
  - down only: ypat += PAT_STEP, clamped at V_RES−1−PAT_H/2.
  - both or neither: no move.
  - Collision tests use `ypat_old`, the value before this tick's move.

## Timing
- Latency: vsync falling edge sampled at cycle n → tick at n+1 → outputs change at n+2.
- Outputs hold for the rest of the frame.
- All outputs are registered.
- Reset values: xball=`SERVE_X`, yball=`V_RES/2`, xpat=`PAT_X`, ypat=`V_RES/2`, hits=0, misses=0, state=IDLE, vx=+`VX0`, vy=+`VY0`, serve-sign toggle=0, miss frame counter=0.
- Reset mid-operation: the next clk edge with `reset`=0 restores all reset values from any state. Edge detectors are also cleared, so a held `serve` does not re-trigger after reset.
- Serve edge coinciding with a tick: the serve is taken; the first ball move happens on the next tick.
- `hits` saturates at 255.
- `misses` never exceeds `MAX_MISS`.

## Structure
- Package `pong_pkg`:
  - FSM state enum.
  - Default geometry and velocity constants.
  - 11-bit coordinate and 12-bit signed-velocity typedefs.
- Sub-module `paddle_ctrl`:
  - Inputs: tick, `pat_up`, `pat_dn`, enable.
  - Outputs: `ypat` with clamping, plus `ypat_old`.
- Ball FSM, reflection logic and counters live in `ball_engine`.

## Test plan
- Reset: hold `reset`=0 for 3 cycles, then 5 vsync pulses with no serve → xball=200, yball=512, ypat=512, hits=0, state=0 throughout.
- Serve and bottom wall: serve edge, then ticks with no paddle input →
  - tick 1: xball=206, yball=516.
  - tick 126: yball=1013.
  - tick 127: yball=1009.
- Paddle hit: as above, holding `pat_dn` → ypat clamps at 973; tick 147 gives xball=1080, vx negative, hits=1.
- Miss: hold `pat_up` (ypat=50) and serve → ball reaches xball=1269 → state=2, misses=1; after 60 ticks state=0, xball=200, yball=512.
- Game over: 9 consecutive misses → state=3 with positions frozen; serve edge → hits=0, misses=0, state=0.
- Edge cases:
  - `pat_up` and `pat_dn` both high → ypat unchanged.
  - `reset`=0 pulsed mid-PLAY → all outputs at reset values on the next cycle.
